// File: rtl/scntl_result_collector_if.sv
// Signal bundle between scntl_result_collector and its neighbours: start/config, stOp result
// channel, SIMD regFile delivery port and status. 'master' is the collector side.
interface scntl_result_collector_if #(
    parameter int NUM_LANES     = 32,
    parameter int LANE_ID_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int PE_ID_WIDTH   = 8
);
    logic [PE_ID_WIDTH-1:0]               peId;
    logic                                 cfg__scntl__start;
    logic [NUM_LANES-1:0]                 cfg__scntl__lane_enable;
    logic                                 stop__scntl__valid;
    logic                                 scntl__stop__ready;
    logic [LANE_ID_WIDTH-1:0]             stop__scntl__lane;
    logic [DATA_WIDTH-1:0]                stop__scntl__data;
    logic [NUM_LANES-1:0]                 scntl__simd__lane_valid;
    logic [DATA_WIDTH-1:0]                scntl__simd__data;
    logic                                 simd__scntl__ready;
    logic                                 scntl__simd__complete;
    logic                                 scntl__status__busy;
    logic                                 scntl__status__error;
    logic [PE_ID_WIDTH+LANE_ID_WIDTH-1:0] scntl__status__err_info;

    modport master (
        input  peId, cfg__scntl__start, cfg__scntl__lane_enable,
        input  stop__scntl__valid, stop__scntl__lane, stop__scntl__data,
        input  simd__scntl__ready,
        output scntl__stop__ready, scntl__simd__lane_valid, scntl__simd__data,
        output scntl__simd__complete, scntl__status__busy, scntl__status__error,
        output scntl__status__err_info
    );

    modport slave (
        output peId, cfg__scntl__start, cfg__scntl__lane_enable,
        output stop__scntl__valid, stop__scntl__lane, stop__scntl__data,
        output simd__scntl__ready,
        input  scntl__stop__ready, scntl__simd__lane_valid, scntl__simd__data,
        input  scntl__simd__complete, scntl__status__busy, scntl__status__error,
        input  scntl__status__err_info
    );
endinterface

// File: rtl/scntl_result_collector.sv
// Collects per-lane stOp results through a small FIFO and hands them one at a time to the SIMD regFile.
// Optional idle timeout enabled by defining SCNTL_RESULT_TIMEOUT_EN.
module scntl_result_collector #(
    parameter int NUM_LANES      = 32,
    parameter int LANE_ID_WIDTH  = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int PE_ID_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                      clk,
    input logic                      reset_poweron,
    scntl_result_collector_if.master bus
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = LANE_ID_WIDTH + DATA_WIDTH;

    if (NUM_LANES != (1 << LANE_ID_WIDTH) || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : gBadParams
        $error("scntl_result_collector: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t                           state_q, state_d;
    logic [NUM_LANES-1:0]             enable_q, enable_d;
    logic [NUM_LANES-1:0]             received_q, received_d;
    logic [ENTRY_W-1:0]               fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]                 wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [PTR_W:0]                   count_q, count_d;
    logic                             outValid_q, outValid_d;
    logic [LANE_ID_WIDTH-1:0]         outLane_q, outLane_d;
    logic [DATA_WIDTH-1:0]            outData_q, outData_d;
    logic                             error_q, error_d;
    logic [PE_ID_WIDTH+LANE_ID_WIDTH-1:0] errInfo_q, errInfo_d;

    logic fifoEmpty, fifoFull, inReady, accept, laneOk, push, drop;
    logic outFree, pop, bypass, fifoWrite, allReceived, collectDone, draining;

`ifdef SCNTL_RESULT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]         idleCnt_q, idleCnt_d;
    logic                     draining_q, draining_d;
    logic [LANE_ID_WIDTH-1:0] missingLane;

    assign draining = draining_q;

    // Lowest enabled lane that never reported, recorded as the culprit of a timeout.
    always_comb begin
        missingLane = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (enable_q[i] && !received_q[i]) missingLane = LANE_ID_WIDTH'(i);
        end
    end
`else
    assign draining = 1'b0;
`endif

    assign fifoEmpty   = (count_q == '0);
    assign fifoFull    = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign inReady     = (state_q == COLLECT) && !fifoFull && !draining;
    assign accept      = bus.stop__scntl__valid && inReady;
    assign laneOk      = enable_q[bus.stop__scntl__lane] && !received_q[bus.stop__scntl__lane];
    assign push        = accept && laneOk;
    assign drop        = accept && !laneOk;
    assign outFree     = !outValid_q || bus.simd__scntl__ready;
    assign pop         = outFree && !fifoEmpty;
    // An empty FIFO lets a fresh result skip straight into the output register.
    assign bypass      = outFree && fifoEmpty && push;
    assign fifoWrite   = push && !bypass;
    assign allReceived = (received_q == enable_q);
    assign collectDone = fifoEmpty && !outValid_q && (allReceived || draining);

    always_ff @(posedge clk) begin
        if (reset_poweron) state_q <= IDLE;
        else               state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.cfg__scntl__start)
                         state_d = (|bus.cfg__scntl__lane_enable) ? COLLECT : DONE;
            COLLECT: if (collectDone) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        enable_d   = enable_q;
        received_d = received_q;
        error_d    = error_q;
        errInfo_d  = errInfo_q;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        outValid_d = outValid_q;
        outLane_d  = outLane_q;
        outData_d  = outData_q;

        if (fifoWrite) wrPtr_d = wrPtr_q + PTR_W'(1);
        if (pop)       rdPtr_d = rdPtr_q + PTR_W'(1);
        if (fifoWrite && !pop)      count_d = count_q + (PTR_W + 1)'(1);
        else if (pop && !fifoWrite) count_d = count_q - (PTR_W + 1)'(1);

        if (outFree) begin
            if (pop) begin
                outValid_d             = 1'b1;
                {outLane_d, outData_d} = fifoMem_q[rdPtr_q];
            end else if (bypass) begin
                outValid_d = 1'b1;
                outLane_d  = bus.stop__scntl__lane;
                outData_d  = bus.stop__scntl__data;
            end else begin
                outValid_d = 1'b0;
            end
        end

        if (push) received_d[bus.stop__scntl__lane] = 1'b1;
        if (drop) begin
            error_d = 1'b1;
            if (!error_q) errInfo_d = {bus.peId, bus.stop__scntl__lane};
        end

        if (bus.cfg__scntl__start) begin
            if (state_q == IDLE) begin
                enable_d   = bus.cfg__scntl__lane_enable;
                received_d = '0;
                error_d    = 1'b0;
                errInfo_d  = '0;
            end else begin
                error_d = 1'b1;
            end
        end
    end

`ifdef SCNTL_RESULT_TIMEOUT_EN
    // Idle cycles in COLLECT; expiry stops intake and lets the pipeline drain before DONE.
    always_comb begin
        idleCnt_d  = idleCnt_q;
        draining_d = draining_q;
        if (state_q == COLLECT && !draining_q) begin
            if (accept) begin
                idleCnt_d = '0;
            end else if (idleCnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                draining_d = 1'b1;
            end else begin
                idleCnt_d = idleCnt_q + TMO_W'(1);
            end
        end
        if (bus.cfg__scntl__start && state_q == IDLE) begin
            idleCnt_d  = '0;
            draining_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            idleCnt_q  <= '0;
            draining_q <= 1'b0;
        end else begin
            idleCnt_q  <= idleCnt_d;
            draining_q <= draining_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            enable_q   <= '0;
            received_q <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            outValid_q <= 1'b0;
            outLane_q  <= '0;
            outData_q  <= '0;
            error_q    <= 1'b0;
            errInfo_q  <= '0;
        end else begin
            enable_q   <= enable_d;
            received_q <= received_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            outValid_q <= outValid_d;
            outLane_q  <= outLane_d;
            outData_q  <= outData_d;
`ifdef SCNTL_RESULT_TIMEOUT_EN
            if (state_q == COLLECT && !draining_q && !accept &&
                idleCnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                error_q <= 1'b1;
                if (!error_q) errInfo_q <= {bus.peId, missingLane};
                else          errInfo_q <= errInfo_d;
            end else begin
                error_q   <= error_d;
                errInfo_q <= errInfo_d;
            end
`else
            error_q    <= error_d;
            errInfo_q  <= errInfo_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (fifoWrite) fifoMem_q[wrPtr_q] <= {bus.stop__scntl__lane, bus.stop__scntl__data};
    end

    assign bus.scntl__stop__ready      = inReady;
    assign bus.scntl__simd__lane_valid = outValid_q ? (NUM_LANES'(1) << outLane_q) : '0;
    assign bus.scntl__simd__data       = outData_q;
    assign bus.scntl__simd__complete   = (state_q == DONE);
    assign bus.scntl__status__busy     = (state_q != IDLE);
    assign bus.scntl__status__error    = error_q;
    assign bus.scntl__status__err_info = errInfo_q;
endmodule

// File: tb/tb_scntl_result_collector.sv
// Directed and randomized checks of scntl_result_collector against a queue-based model of
// accepted-but-undelivered results.
module tb_scntl_result_collector;
    localparam int NUM_LANES      = 32;
    localparam int LANE_ID_WIDTH  = 5;
    localparam int DATA_WIDTH     = 32;
    localparam int FIFO_DEPTH     = 4;
    localparam int PE_ID_WIDTH    = 8;
    localparam int TIMEOUT_CYCLES = 1024;
    localparam logic [PE_ID_WIDTH-1:0] PE_ID = 8'h5C;

    typedef struct packed {
        logic [LANE_ID_WIDTH-1:0] lane;
        logic [DATA_WIDTH-1:0]    data;
    } result_t;

    typedef enum {M_IDLE, M_COLLECT, M_DONE} mphase_t;

    logic clk = 1'b0;
    logic reset_poweron;

    always #5 clk = ~clk;

    scntl_result_collector_if #(
        .NUM_LANES(NUM_LANES), .LANE_ID_WIDTH(LANE_ID_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .PE_ID_WIDTH(PE_ID_WIDTH)
    ) bus ();

    scntl_result_collector #(
        .NUM_LANES(NUM_LANES), .LANE_ID_WIDTH(LANE_ID_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH), .PE_ID_WIDTH(PE_ID_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .reset_poweron(reset_poweron),
        .bus(bus)
    );

    // Model: results accepted but not yet handed to the regFile, in arrival order.
    result_t                              expQ[$];
    result_t                              stimQ[$];
    mphase_t                              mPhase;
    logic [NUM_LANES-1:0]                 mEnable, mRecv;
    logic                                 mError;
    logic [PE_ID_WIDTH+LANE_ID_WIDTH-1:0] mErrInfo;

    int assertCount, failCount;
    int dutDelivered, dutAccepted, completeSeen, busySeen;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit modelReady();
        return (mPhase == M_COLLECT) && (expQ.size() < FIFO_DEPTH + 1);
    endfunction

    task automatic checkModel();
        logic [NUM_LANES-1:0] expValid;
        expValid = '0;
        if (expQ.size() != 0) expValid[expQ[0].lane] = 1'b1;
        if (bus.scntl__simd__complete === 1'b1) completeSeen++;
        if (bus.scntl__status__busy === 1'b1) busySeen++;
        checkOutput("lane_valid", 64'(bus.scntl__simd__lane_valid), 64'(expValid));
        if (expQ.size() != 0)
            checkOutput("simd_data", 64'(bus.scntl__simd__data), 64'(expQ[0].data));
        checkOutput("stop_ready", 64'(bus.scntl__stop__ready), 64'(modelReady()));
        checkOutput("busy", 64'(bus.scntl__status__busy), 64'(mPhase != M_IDLE));
        checkOutput("complete", 64'(bus.scntl__simd__complete), 64'(mPhase == M_DONE));
        checkOutput("error", 64'(bus.scntl__status__error), 64'(mError));
        checkOutput("err_info", 64'(bus.scntl__status__err_info), 64'(mErrInfo));
    endtask

    task automatic applyStimulus(input bit valid, input logic [LANE_ID_WIDTH-1:0] lane,
                                 input logic [DATA_WIDTH-1:0] data, input bit simdReady,
                                 input bit start, input logic [NUM_LANES-1:0] mask,
                                 output bit accepted);
        bit      acc, deliver, doneNow;
        mphase_t nextPhase;
        bus.stop__scntl__valid      = valid;
        bus.stop__scntl__lane       = lane;
        bus.stop__scntl__data       = data;
        bus.simd__scntl__ready      = simdReady;
        bus.cfg__scntl__start       = start;
        bus.cfg__scntl__lane_enable = mask;
        if (valid && bus.scntl__stop__ready === 1'b1) dutAccepted++;
        if (bus.scntl__simd__lane_valid !== '0 && simdReady) dutDelivered++;

        acc       = valid && modelReady();
        deliver   = (expQ.size() != 0) && simdReady;
        doneNow   = (mPhase == M_COLLECT) && (mRecv == mEnable) && (expQ.size() == 0);
        nextPhase = mPhase;
        if (deliver) void'(expQ.pop_front());
        if (acc) begin
            if (mEnable[lane] && !mRecv[lane]) begin
                mRecv[lane] = 1'b1;
                expQ.push_back(result_t'({lane, data}));
            end else begin
                if (!mError) mErrInfo = {PE_ID, lane};
                mError = 1'b1;
            end
        end
        case (mPhase)
            M_IDLE: if (start) begin
                mEnable   = mask;
                mRecv     = '0;
                mError    = 1'b0;
                mErrInfo  = '0;
                nextPhase = (mask != '0) ? M_COLLECT : M_DONE;
            end
            M_COLLECT: if (doneNow) nextPhase = M_DONE;
            default:   nextPhase = M_IDLE;
        endcase
        if (start && mPhase != M_IDLE) mError = 1'b1;
        mPhase   = nextPhase;
        accepted = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset_poweron               = 1'b1;
        bus.stop__scntl__valid      = 1'b0;
        bus.stop__scntl__lane       = '0;
        bus.stop__scntl__data       = '0;
        bus.simd__scntl__ready      = 1'b0;
        bus.cfg__scntl__start       = 1'b0;
        bus.cfg__scntl__lane_enable = '0;
        @(posedge clk);
        #1;
        reset_poweron = 1'b0;
        expQ.delete();
        mPhase   = M_IDLE;
        mEnable  = '0;
        mRecv    = '0;
        mError   = 1'b0;
        mErrInfo = '0;
    endtask

    task automatic runCollection(input logic [NUM_LANES-1:0] mask, input int holdLow,
                                 input bit randomReady, input int bubblePct, input bit spurious);
        bit accepted, offering, valid, simdReady, finished, startNow;
        dutDelivered = 0;
        dutAccepted  = 0;
        completeSeen = 0;
        busySeen     = 0;
        offering     = 1'b0;
        finished     = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, mask, accepted);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checkModel();
            if (mPhase == M_IDLE) begin
                finished = 1'b1;
                break;
            end
            if (holdLow > 0 && cyc == holdLow)
                checkOutput("accepts_while_held", 64'(dutAccepted), 64'(FIFO_DEPTH + 1));
            if (mPhase != M_COLLECT) begin
                stimQ.delete();
                offering = 1'b0;
            end
            if (offering) valid = 1'b1;
            else          valid = (stimQ.size() != 0) && ($urandom_range(99) >= bubblePct);
            if (cyc < holdLow)    simdReady = 1'b0;
            else if (randomReady) simdReady = ($urandom_range(99) < 70);
            else                  simdReady = 1'b1;
            startNow = spurious && (cyc == 2);
            if (valid) applyStimulus(1'b1, stimQ[0].lane, stimQ[0].data, simdReady, startNow, '0, accepted);
            else       applyStimulus(1'b0, '0, '0, simdReady, startNow, '0, accepted);
            if (accepted) begin
                void'(stimQ.pop_front());
                offering = 1'b0;
            end else begin
                offering = valid;
            end
        end
        checkOutput("collection_finished", 64'(finished), 64'(1));
    endtask

    task automatic randomRuns();
        logic [NUM_LANES-1:0] mask;
        int                   lanes[$];
        int                   j, t;
        bit                   acc;
        for (int r = 0; r < 30; r++) begin
            if (r % 3 == 0) mask = $urandom;
            else            mask = $urandom & $urandom & $urandom;
            if (mask == '0) mask = NUM_LANES'(1) << $urandom_range(NUM_LANES - 1);
            lanes.delete();
            for (int i = 0; i < NUM_LANES; i++) if (mask[i]) lanes.push_back(i);
            for (int i = lanes.size() - 1; i > 0; i--) begin
                j        = int'($urandom_range(i));
                t        = lanes[i];
                lanes[i] = lanes[j];
                lanes[j] = t;
            end
            stimQ.delete();
            foreach (lanes[i]) begin
                if ($urandom_range(99) < 20)
                    stimQ.push_back(result_t'({LANE_ID_WIDTH'($urandom_range(NUM_LANES - 1)), DATA_WIDTH'($urandom)}));
                stimQ.push_back(result_t'({LANE_ID_WIDTH'(lanes[i]), DATA_WIDTH'($urandom)}));
            end
            runCollection(mask, 0, 1'b1, 25, ($urandom_range(3) == 0));
            checkOutput("rand_complete_once", 64'(completeSeen), 64'(1));
            applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, acc);
            checkModel();
        end
    endtask

    initial begin
        bit acc;
        assertCount = 0;
        failCount   = 0;
        bus.peId    = PE_ID;
        doReset();
        checkModel();

        // Back-to-back lanes 0..3 with the regFile always ready.
        stimQ.delete();
        for (int i = 0; i < 4; i++)
            stimQ.push_back(result_t'({LANE_ID_WIDTH'(i), DATA_WIDTH'(32'hA0 + i)}));
        runCollection(32'h0000_000F, 0, 1'b0, 0, 1'b0);
        checkOutput("t1_delivered", 64'(dutDelivered), 64'(4));
        checkOutput("t1_complete_once", 64'(completeSeen), 64'(1));
        checkOutput("t1_error", 64'(bus.scntl__status__error), 64'(0));

        // Backpressure from the regFile fills FIFO plus output register.
        stimQ.delete();
        for (int i = 0; i < 6; i++)
            stimQ.push_back(result_t'({LANE_ID_WIDTH'(i), DATA_WIDTH'(32'hB0 + i)}));
        runCollection(32'h0000_003F, 10, 1'b0, 0, 1'b0);
        checkOutput("t2_delivered", 64'(dutDelivered), 64'(6));

        // Duplicate lane 0.
        stimQ.delete();
        stimQ.push_back(result_t'({LANE_ID_WIDTH'(0), DATA_WIDTH'(32'hC0)}));
        stimQ.push_back(result_t'({LANE_ID_WIDTH'(0), DATA_WIDTH'(32'hC1)}));
        runCollection(32'h0000_0001, 0, 1'b0, 0, 1'b0);
        checkOutput("t3_delivered", 64'(dutDelivered), 64'(1));
        checkOutput("t3_error", 64'(bus.scntl__status__error), 64'(1));
        checkOutput("t3_err_info", 64'(bus.scntl__status__err_info), 64'({PE_ID, 5'd0}));

        // Empty enable mask.
        stimQ.delete();
        runCollection(32'h0, 0, 1'b0, 0, 1'b0);
        checkOutput("t4_busy_cycles", 64'(busySeen), 64'(1));
        checkOutput("t4_complete_once", 64'(completeSeen), 64'(1));

        // Start pulse while already collecting.
        stimQ.delete();
        stimQ.push_back(result_t'({LANE_ID_WIDTH'(1), DATA_WIDTH'(32'hD1)}));
        stimQ.push_back(result_t'({LANE_ID_WIDTH'(0), DATA_WIDTH'(32'hD0)}));
        runCollection(32'h0000_0003, 0, 1'b0, 60, 1'b1);
        checkOutput("t6_spurious_error", 64'(bus.scntl__status__error), 64'(1));

        // Reset with two results buffered.
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 32'h0000_000F, acc);
        applyStimulus(1'b1, 5'd0, 32'hE0, 1'b0, 1'b0, '0, acc);
        applyStimulus(1'b1, 5'd1, 32'hE1, 1'b0, 1'b0, '0, acc);
        checkModel();
        completeSeen = 0;
        doReset();
        checkOutput("t5_lane_valid", 64'(bus.scntl__simd__lane_valid), 64'(0));
        checkOutput("t5_ready", 64'(bus.scntl__stop__ready), 64'(0));
        checkOutput("t5_busy", 64'(bus.scntl__status__busy), 64'(0));
        for (int i = 0; i < 5; i++) begin
            checkModel();
            applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, acc);
        end
        checkOutput("t5_no_complete", 64'(completeSeen), 64'(0));

        randomRuns();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
